// File: rtl/fg_bbox.sv
// Foreground bounding-box extractor: two-stage pixel pipeline that reports the box,
// presence flag and (with FG_BBOX_COUNT_EN defined) foreground count once per frame.
module fg_bbox #(
    parameter int             P_W     = 12,
    parameter int             C_W     = 8,
    parameter int             FRAME_X = 640,
    parameter int             FRAME_Y = 480,
    parameter logic [C_W-1:0] BG_R    = '0,
    parameter logic [C_W-1:0] BG_G    = '0,
    parameter logic [C_W-1:0] BG_B    = '0,
    parameter logic [C_W+1:0] THRESH  = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             i_valid,
    input  logic [C_W-1:0]   i_R,
    input  logic [C_W-1:0]   i_G,
    input  logic [C_W-1:0]   i_B,
    output logic             o_done,
    output logic             o_found,
    output logic [P_W-1:0]   o_x_min,
    output logic [P_W-1:0]   o_x_max,
    output logic [P_W-1:0]   o_y_min,
    output logic [P_W-1:0]   o_y_max,
    output logic [2*P_W-1:0] o_fg_count,
    output logic             o_busy,
    output logic [1:0]       o_dbg_state
);

    localparam logic [P_W-1:0] LP_X_LAST = P_W'(FRAME_X - 1);
    localparam logic [P_W-1:0] LP_Y_LAST = P_W'(FRAME_Y - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [P_W-1:0] r_cnt_x;
    logic [P_W-1:0] r_cnt_y;
    logic           w_acc00;

    assign w_acc00 = i_valid && (r_cnt_x == '0) && (r_cnt_y == '0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_x <= '0;
            r_cnt_y <= '0;
        end else if (i_valid) begin
            if (r_cnt_x == LP_X_LAST) begin
                r_cnt_x <= '0;
                r_cnt_y <= (r_cnt_y == LP_Y_LAST) ? '0 : r_cnt_y + 1'b1;
            end else begin
                r_cnt_x <= r_cnt_x + 1'b1;
            end
        end
    end

    // Stage 1: per-channel absolute distance from the mask colour, summed without overflow.
    logic [C_W-1:0] w_dr;
    logic [C_W-1:0] w_dg;
    logic [C_W-1:0] w_db;
    logic [C_W+1:0] w_dist;

    always_comb begin
        w_dr   = (i_R >= BG_R) ? (i_R - BG_R) : (BG_R - i_R);
        w_dg   = (i_G >= BG_G) ? (i_G - BG_G) : (BG_G - i_G);
        w_db   = (i_B >= BG_B) ? (i_B - BG_B) : (BG_B - i_B);
        w_dist = {2'b00, w_dr} + {2'b00, w_dg} + {2'b00, w_db};
    end

    logic           r_s1_valid;
    logic [C_W+1:0] r_s1_dist;
    logic [P_W-1:0] r_s1_x;
    logic [P_W-1:0] r_s1_y;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_dist  <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_dist <= w_dist;
                r_s1_x    <= r_cnt_x;
                r_s1_y    <= r_cnt_y;
            end
        end
    end

    // Stage 2: the first pixel folds into freshly initialised accumulators, so a new
    // frame can start the cycle right after the previous one finished.
    logic           w_s1_first;
    logic           w_s1_last;
    logic           w_s1_fg;
    logic           r_found;
    logic [P_W-1:0] r_x_min;
    logic [P_W-1:0] r_x_max;
    logic [P_W-1:0] r_y_min;
    logic [P_W-1:0] r_y_max;
    logic           w_b_found;
    logic [P_W-1:0] w_b_x_min;
    logic [P_W-1:0] w_b_x_max;
    logic [P_W-1:0] w_b_y_min;
    logic [P_W-1:0] w_b_y_max;
    logic           w_n_found;
    logic [P_W-1:0] w_n_x_min;
    logic [P_W-1:0] w_n_x_max;
    logic [P_W-1:0] w_n_y_min;
    logic [P_W-1:0] w_n_y_max;

    assign w_s1_first = r_s1_valid && (r_s1_x == '0) && (r_s1_y == '0);
    assign w_s1_last  = r_s1_valid && (r_s1_x == LP_X_LAST) && (r_s1_y == LP_Y_LAST);
    assign w_s1_fg    = r_s1_valid && (r_s1_dist > THRESH);

    always_comb begin
        w_b_found = w_s1_first ? 1'b0      : r_found;
        w_b_x_min = w_s1_first ? LP_X_LAST : r_x_min;
        w_b_x_max = w_s1_first ? '0        : r_x_max;
        w_b_y_min = w_s1_first ? LP_Y_LAST : r_y_min;
        w_b_y_max = w_s1_first ? '0        : r_y_max;
        w_n_found = w_b_found;
        w_n_x_min = w_b_x_min;
        w_n_x_max = w_b_x_max;
        w_n_y_min = w_b_y_min;
        w_n_y_max = w_b_y_max;
        if (w_s1_fg) begin
            w_n_found = 1'b1;
            if (r_s1_x < w_b_x_min) w_n_x_min = r_s1_x;
            if (r_s1_x > w_b_x_max) w_n_x_max = r_s1_x;
            if (r_s1_y < w_b_y_min) w_n_y_min = r_s1_y;
            if (r_s1_y > w_b_y_max) w_n_y_max = r_s1_y;
        end
    end

    logic           r_done;
    logic           r_o_found;
    logic [P_W-1:0] r_o_x_min;
    logic [P_W-1:0] r_o_x_max;
    logic [P_W-1:0] r_o_y_min;
    logic [P_W-1:0] r_o_y_max;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_found   <= 1'b0;
            r_x_min   <= LP_X_LAST;
            r_x_max   <= '0;
            r_y_min   <= LP_Y_LAST;
            r_y_max   <= '0;
            r_done    <= 1'b0;
            r_o_found <= 1'b0;
            r_o_x_min <= '0;
            r_o_x_max <= '0;
            r_o_y_min <= '0;
            r_o_y_max <= '0;
        end else begin
            if (r_s1_valid) begin
                r_found <= w_n_found;
                r_x_min <= w_n_x_min;
                r_x_max <= w_n_x_max;
                r_y_min <= w_n_y_min;
                r_y_max <= w_n_y_max;
            end
            r_done <= w_s1_last;
            if (w_s1_last) begin
                r_o_found <= w_n_found;
                r_o_x_min <= w_n_found ? w_n_x_min : '0;
                r_o_x_max <= w_n_found ? w_n_x_max : '0;
                r_o_y_min <= w_n_found ? w_n_y_min : '0;
                r_o_y_max <= w_n_found ? w_n_y_max : '0;
            end
        end
    end

`ifdef FG_BBOX_COUNT_EN
    logic [2*P_W-1:0] r_fg_cnt;
    logic [2*P_W-1:0] r_fg_cnt_out;
    logic [2*P_W-1:0] w_b_cnt;
    logic [2*P_W-1:0] w_n_cnt;

    always_comb begin
        w_b_cnt = w_s1_first ? '0 : r_fg_cnt;
        w_n_cnt = w_b_cnt;
        if (w_s1_fg && (w_b_cnt != '1)) w_n_cnt = w_b_cnt + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fg_cnt     <= '0;
            r_fg_cnt_out <= '0;
        end else begin
            if (r_s1_valid) r_fg_cnt <= w_n_cnt;
            if (w_s1_last) r_fg_cnt_out <= w_n_cnt;
        end
    end

    assign o_fg_count = r_fg_cnt_out;
`else
    assign o_fg_count = '0;
`endif

    // A frame whose first pixel lands while the previous one is still closing is
    // remembered in r_pend so IDLE re-enters ACCUM for it.
    logic [1:0] r_state;
    logic       r_pend;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_pend <= 1'b0;
            else if (w_acc00)      r_pend <= 1'b1;
            case (r_state)
                S_IDLE:   if (w_acc00 || r_pend) r_state <= S_ACCUM;
                S_ACCUM:  if (w_s1_last) r_state <= S_REPORT;
                S_REPORT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign o_done      = r_done;
    assign o_found     = r_o_found;
    assign o_x_min     = r_o_x_min;
    assign o_x_max     = r_o_x_max;
    assign o_y_min     = r_o_y_min;
    assign o_y_max     = r_o_y_max;
    assign o_busy      = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fg_bbox.sv
// Bench for fg_bbox on an 8x4 frame: driver pushes hand-computed frame results,
// a monitor pops and compares them on every o_done.
module tb_fg_bbox;

    localparam int P_W  = 12;
    localparam int C_W  = 8;
    localparam int FX   = 8;
    localparam int FY   = 4;
    localparam int NPIX = FX * FY;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             i_valid;
    logic [C_W-1:0]   i_R;
    logic [C_W-1:0]   i_G;
    logic [C_W-1:0]   i_B;
    logic             o_done;
    logic             o_found;
    logic [P_W-1:0]   o_x_min;
    logic [P_W-1:0]   o_x_max;
    logic [P_W-1:0]   o_y_min;
    logic [P_W-1:0]   o_y_max;
    logic [2*P_W-1:0] o_fg_count;
    logic             o_busy;
    logic [1:0]       o_dbg_state;

    fg_bbox #(
        .P_W(P_W), .C_W(C_W), .FRAME_X(FX), .FRAME_Y(FY),
        .BG_R(8'd0), .BG_G(8'd0), .BG_B(8'd0), .THRESH(10'd32)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_valid(i_valid),
        .i_R(i_R), .i_G(i_G), .i_B(i_B),
        .o_done(o_done), .o_found(o_found),
        .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min), .o_y_max(o_y_max),
        .o_fg_count(o_fg_count), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
    );

    typedef struct packed {
        logic             found;
        logic [P_W-1:0]   x_min;
        logic [P_W-1:0]   x_max;
        logic [P_W-1:0]   y_min;
        logic [P_W-1:0]   y_max;
        logic [2*P_W-1:0] cnt;
        logic [31:0]      cyc;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    logic [3*C_W-1:0] pix [NPIX];

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // scoreboard monitor
    always @(negedge sys_clk) begin
        if (sys_rst_n && o_done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got o_done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("found",      o_found,    mon_e.found);
                check("x_min",      o_x_min,    mon_e.x_min);
                check("x_max",      o_x_max,    mon_e.x_max);
                check("y_min",      o_y_min,    mon_e.y_min);
                check("y_max",      o_y_max,    mon_e.y_max);
                check("fg_count",   o_fg_count, mon_e.cnt);
                check("done_cycle", cyc,        mon_e.cyc);
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic clear_pix();
        for (int i = 0; i < NPIX; i++) pix[i] = '0;
    endtask

    task automatic set_pix(input int x, input int y, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b);
        pix[y*FX+x] = {r, g, b};
    endtask

    task automatic send_frame(input int gap_max, input logic f, input int x0, input int x1,
                              input int y0, input int y1, input int cnt);
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
            @(negedge sys_clk);
            i_valid = 1'b1;
            {i_R, i_G, i_B} = pix[i];
            if (i == NPIX - 1) begin
                e.found = f;
                e.x_min = P_W'(x0);
                e.x_max = P_W'(x1);
                e.y_min = P_W'(y0);
                e.y_max = P_W'(y1);
`ifdef FG_BBOX_COUNT_EN
                e.cnt = (2*P_W)'(cnt);
`else
                e.cnt = '0;
`endif
                e.cyc = 32'(cyc + 2);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge sys_clk);
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        i_valid   = 1'b0;
        i_R = '0; i_G = '0; i_B = '0;
        clear_pix();
        repeat (3) @(negedge sys_clk);
        check("rst_done",  o_done, 0);
        check("rst_found", o_found, 0);
        check("rst_x_max", o_x_max, 0);
        check("rst_y_max", o_y_max, 0);
        check("rst_count", o_fg_count, 0);
        check("rst_busy",  o_busy, 0);
        sys_rst_n = 1'b1;
        idle(2);

        // all background
        clear_pix();
        send_frame(0, 1'b0, 0, 0, 0, 0, 0);
        idle(1);
        drain();
        idle(2);
        check("idle_busy", o_busy, 0);

        // single foreground pixel, then hold check
        clear_pix();
        set_pix(3, 2, 8'd40, 8'd0, 8'd0);
        send_frame(0, 1'b1, 3, 3, 2, 2, 1);
        idle(1);
        drain();
        idle(5);
        check("hold_x_min", o_x_min, 3);
        check("hold_y_max", o_y_max, 2);
        check("hold_found", o_found, 1);

        // dist == THRESH is background; last pixel is foreground
        clear_pix();
        set_pix(1, 1, 8'd11, 8'd11, 8'd10);
        set_pix(7, 3, 8'd20, 8'd20, 8'd0);
        send_frame(0, 1'b1, 7, 7, 3, 3, 1);
        idle(1);
        drain();

        // back-to-back frames with random gaps inside each frame
        clear_pix();
        set_pix(0, 0, 8'd40, 8'd0, 8'd0);
        send_frame(3, 1'b1, 0, 0, 0, 0, 1);
        clear_pix();
        set_pix(5, 1, 8'd0, 8'd0, 8'd60);
        send_frame(3, 1'b1, 5, 5, 1, 1, 1);
        idle(1);
        drain();
        idle(3);

        // reset mid-frame after 10 pixels
        clear_pix();
        set_pix(4, 0, 8'd100, 8'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            i_valid = 1'b1;
            {i_R, i_G, i_B} = pix[i];
        end
        idle(1);
        check("mid_busy", o_busy, 1);
        sys_rst_n = 1'b0;
        idle(2);
        check("mrst_busy",  o_busy, 0);
        check("mrst_found", o_found, 0);
        check("mrst_x_max", o_x_max, 0);
        sys_rst_n = 1'b1;
        idle(2);
        clear_pix();
        set_pix(2, 1, 8'd0, 8'd50, 8'd0);
        set_pix(6, 3, 8'd33, 8'd0, 8'd0);
        send_frame(0, 1'b1, 2, 6, 1, 3, 2);
        idle(1);
        drain();

        // full foreground
        for (int i = 0; i < NPIX; i++) pix[i] = {8'd40, 8'd0, 8'd0};
        send_frame(0, 1'b1, 0, 7, 0, 3, 32);
        idle(1);
        drain();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fg_bbox.md
FG_BBOX -- requirements
Module: fg_bbox

Interface
REQ-001 SHALL provide the following parameters (name, default, meaning):
- P_W, 12: position width.
- C_W, 8: colour channel width.
- FRAME_X, 640: pixels per line.
- FRAME_Y, 480: lines per frame.
- BG_R / BG_G / BG_B, 0 / 0 / 0: background colour written by the upstream window-mask stage.
- THRESH, 32: foreground distance threshold, width C_W+2.

REQ-002 SHALL provide the following ports (name, direction, width, meaning):
- sys_clk, in, 1: clock.
- sys_rst_n, in, 1: reset, asynchronous, active-low.
- i_valid, in, 1: pixel strobe.
- i_R / i_G / i_B, in, C_W: masked pixel colour.
- o_done, out, 1: one-cycle frame-result pulse.
- o_found, out, 1: frame contained at least one foreground pixel.
- o_x_min / o_x_max / o_y_min / o_y_max, out, P_W: foreground bounding box.
- o_fg_count, out, 2*P_W: foreground pixel count.
- o_busy, out, 1: a frame is being accumulated.

Function
REQ-003 SHALL keep cnt_x/cnt_y advancing only on i_valid: cnt_x wraps at FRAME_X-1 and increments cnt_y; cnt_y wraps at FRAME_Y-1 back to 0.
REQ-004 SHALL compute, in stage 1 (registered), dist = |R-BG_R| + |G-BG_G| + |B-BG_B| at width C_W+2 without overflow, together with the pixel position and a valid flag.
REQ-005 SHALL classify a stage-1 pixel as foreground when dist > THRESH (strictly greater); dist == THRESH is background.
REQ-006 SHALL implement states IDLE, ACCUM and REPORT.
- IDLE -> ACCUM on acceptance of pixel (0,0).
- ACCUM -> REPORT when stage 2 processes pixel (FRAME_X-1, FRAME_Y-1).
- REPORT -> IDLE unconditionally after one cycle.
REQ-007 SHALL, when pixel (0,0) reaches stage 2, initialise the accumulators before folding that pixel in: x_min = FRAME_X-1, y_min = FRAME_Y-1, x_max = 0, y_max = 0, found = 0, count = 0.
REQ-008 SHALL, in stage 2, update for each foreground pixel: min/max on x and y, set found, and increment count; background pixels leave all accumulators unchanged.
REQ-009 SHALL include the last pixel of the frame in the accumulation on the same cycle it triggers REPORT.
REQ-010 SHALL latch the results into the outputs and assert o_done for exactly one cycle, 2 cycles after the i_valid of the last pixel.
REQ-011 SHALL drive all four box outputs to 0 when the frame contained no foreground pixel (o_found = 0).
REQ-012 SHALL hold the latched outputs stable until the next o_done.
REQ-013 SHALL saturate the internal count at 2^(2*P_W)-1.
REQ-014 SHALL drive o_busy high in ACCUM and REPORT, low in IDLE.
REQ-015 SHALL tolerate i_valid gaps of any length without corrupting position tracking or accumulation.
REQ-016 SHALL handle back-to-back frames, where pixel (0,0) of frame N+1 arrives the cycle after the last pixel of frame N, without losing either frame's result.

Reset
REQ-017 SHALL, on sys_rst_n low, asynchronously clear the counters, pipeline valid flags, state (IDLE) and all outputs to 0.
REQ-018 SHALL, on reset mid-frame, discard the partial frame and produce no o_done for it; the first pixel after reset is position (0,0).

Configuration
REQ-019 SHALL, with FG_BBOX_COUNT_EN defined, implement the foreground counter and drive o_fg_count with the latched count.
REQ-020 SHALL, with FG_BBOX_COUNT_EN undefined, omit the counter logic and tie o_fg_count to 0; all other behaviour is identical.

Verification (FRAME_X=8, FRAME_Y=4, BG=0, THRESH=32)
REQ-021 All-background frame -> one o_done pulse, o_found=0, box = (0,0,0,0), count=0.
REQ-022 Single pixel RGB=(40,0,0) at (3,2) -> o_found=1, x_min=x_max=3, y_min=y_max=2, count=1.
REQ-023 Pixels (11,11,10) [dist 32] at (1,1) and (20,20,0) [dist 40] at (7,3) -> box (7,7,3,3), count=1; o_done exactly 2 cycles after the last i_valid.
REQ-024 Two back-to-back frames, foreground at (0,0) then at (5,1), with random i_valid gaps -> two o_done pulses reporting (0,0,0,0) and (5,5,1,1).
REQ-025 Reset asserted mid-frame after 10 pixels -> no o_done; the next full frame reports correctly from (0,0).
REQ-026 Full-foreground frame built with FG_BBOX_COUNT_EN undefined -> box (0,7,0,3), o_fg_count=0; the same stimulus with the macro defined -> o_fg_count=32.
